// File: rtl/vga_frame_mem_arbiter.sv
// vga_frame_mem_arbiter
//
// Purpose:
//   Shares one single-port synchronous image RAM (1-cycle read latency)
//   between the VGA display fetch path and a host load/readback port.
//   The display fetch always wins. The host is served in cycles with no
//   display request, optionally restricted to blanking intervals. All RAM
//   port signals are owned here.
//
// Ports:
//   CLK          system clock, posedge
//   RSTN         asynchronous active-low reset
//   IN_BLANK     1 = display outside the active window
//   DISP_REQ     display read request, one cycle per pixel, never stalled
//   DISP_ADDR    display read address, valid with DISP_REQ
//   DISP_DATA    display read data (holds between results)
//   DISP_VALID   DISP_DATA valid, 1-cycle pulse, 2 cycles after DISP_REQ
//   HOST_REQ     host access request, held until HOST_GNT
//   HOST_WE      1 = write, 0 = read
//   HOST_ADDR    host address
//   HOST_WDATA   host write data
//   HOST_GNT     combinational grant: host access issued this cycle
//   HOST_RDATA   host read data (holds between results)
//   HOST_RVALID  HOST_RDATA valid, 1-cycle pulse, 2 cycles after grant
//   HOST_STARVE  sticky flag: host waited STARVE_LIMIT cycles
//   MEM_ADDR     RAM address
//   MEM_WE       RAM write enable
//   MEM_WDATA    RAM write data
//   MEM_RDATA    RAM read data, valid the cycle after MEM_ADDR

module vga_frame_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int BLANK_ONLY   = 0,
  parameter int STARVE_LIMIT = 4095
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IN_BLANK,
  input  logic          DISP_REQ,
  input  logic [AW-1:0] DISP_ADDR,
  output logic [DW-1:0] DISP_DATA,
  output logic          DISP_VALID,
  input  logic          HOST_REQ,
  input  logic          HOST_WE,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [DW-1:0] HOST_WDATA,
  output logic          HOST_GNT,
  output logic [DW-1:0] HOST_RDATA,
  output logic          HOST_RVALID,
  output logic          HOST_STARVE,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } host_state_t;

  host_state_t   host_state;
  logic [15:0]   wait_cnt;
  logic [15:0]   wait_cnt_inc;
  logic          host_window;
  logic          disp_sel;
  logic          host_gnt_c;
  logic [AW-1:0] addr_hold;
  // tag_q[1]: display read in flight, tag_q[0]: host read in flight
  logic [1:0]    tag_q;

  // Grant decision. Everything is gated by RSTN so the RAM port and the
  // grant stay quiet for the whole reset interval, not only after an edge.
  always_comb begin
    host_window = (BLANK_ONLY == 0) || IN_BLANK;
    disp_sel    = RSTN && DISP_REQ;
    host_gnt_c  = RSTN && !DISP_REQ && HOST_REQ && host_window;
  end

  assign HOST_GNT = host_gnt_c;

  // RAM port mux. With no owner the address parks on the last driven value
  // so the RAM does not see spurious address toggles.
  always_comb begin
    MEM_ADDR  = addr_hold;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    if (disp_sel) begin
      MEM_ADDR = DISP_ADDR;
    end else if (host_gnt_c) begin
      MEM_ADDR  = HOST_ADDR;
      MEM_WE    = HOST_WE;
      MEM_WDATA = HOST_WDATA;
    end
  end

  // Registered copy of the address actually presented to the RAM.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      addr_hold <= '0;
    end else begin
      addr_hold <= MEM_ADDR;
    end
  end

  // Read return pipeline: the tag follows each read by one cycle so the
  // RAM data arriving a cycle later can be steered to the right consumer.
  // Only one tag bit can be set at a time, so results come out in issue
  // order at one per cycle. The unselected data output keeps its value.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tag_q       <= 2'b00;
      DISP_DATA   <= '0;
      DISP_VALID  <= 1'b0;
      HOST_RDATA  <= '0;
      HOST_RVALID <= 1'b0;
    end else begin
      tag_q       <= {disp_sel, host_gnt_c && !HOST_WE};
      DISP_VALID  <= tag_q[1];
      HOST_RVALID <= tag_q[0];
      if (tag_q[1]) begin
        DISP_DATA <= MEM_RDATA;
      end
      if (tag_q[0]) begin
        HOST_RDATA <= MEM_RDATA;
      end
    end
  end

  // Saturating increment so a very long stall cannot wrap back to zero.
  always_comb begin
    wait_cnt_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
  end

  // Host wait tracker. Every cycle with HOST_REQ high and no grant counts
  // as one wait cycle; the starve flag is set as soon as the count of wait
  // cycles reaches STARVE_LIMIT and only reset clears it. A host dropping
  // its request without a grant is tolerated and simply restarts the count.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      host_state  <= S_IDLE;
      wait_cnt    <= 16'd0;
      HOST_STARVE <= 1'b0;
    end else begin
      case (host_state)
        S_IDLE: begin
          if (HOST_REQ && !host_gnt_c) begin
            host_state <= S_WAIT;
            wait_cnt   <= wait_cnt_inc;
            if (wait_cnt_inc == 16'(STARVE_LIMIT)) begin
              HOST_STARVE <= 1'b1;
            end
          end else begin
            wait_cnt <= 16'd0;
          end
        end
        S_WAIT: begin
          if (host_gnt_c || !HOST_REQ) begin
            host_state <= S_IDLE;
            wait_cnt   <= 16'd0;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == 16'(STARVE_LIMIT)) begin
              HOST_STARVE <= 1'b1;
            end
          end
        end
        default: begin
          host_state <= S_IDLE;
          wait_cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_mem_arbiter.sv
// tb_vga_frame_mem_arbiter
//
// Directed bench for vga_frame_mem_arbiter. Instance dut_a runs with host
// access in any free cycle and a starve limit of 8, backed by a small RAM
// model; instance dut_b only grants the host during blanking. Inputs change
// on the falling edge; outputs are sampled 1 ns later, which shows the
// combinational grant for the current cycle and the registered outputs
// produced by the previous rising edge.

module tb_vga_frame_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_blank;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        ram_init;

  logic [7:0]  disp_data_a, host_rdata_a, mem_wdata_a, mem_rdata_a;
  logic        disp_valid_a, host_gnt_a, host_rvalid_a, host_starve_a, mem_we_a;
  logic [15:0] mem_addr_a;

  logic [7:0]  disp_data_b, host_rdata_b, mem_wdata_b, mem_rdata_b;
  logic        disp_valid_b, host_gnt_b, host_rvalid_b, host_starve_b, mem_we_b;
  logic [15:0] mem_addr_b;

  logic [7:0]  ram [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_frame_mem_arbiter #(
    .AW(16), .DW(8), .BLANK_ONLY(0), .STARVE_LIMIT(8)
  ) dut_a (
    .CLK(clk), .RSTN(rstn), .IN_BLANK(in_blank),
    .DISP_REQ(disp_req), .DISP_ADDR(disp_addr),
    .DISP_DATA(disp_data_a), .DISP_VALID(disp_valid_a),
    .HOST_REQ(host_req), .HOST_WE(host_we), .HOST_ADDR(host_addr),
    .HOST_WDATA(host_wdata), .HOST_GNT(host_gnt_a),
    .HOST_RDATA(host_rdata_a), .HOST_RVALID(host_rvalid_a),
    .HOST_STARVE(host_starve_a),
    .MEM_ADDR(mem_addr_a), .MEM_WE(mem_we_a), .MEM_WDATA(mem_wdata_a),
    .MEM_RDATA(mem_rdata_a)
  );

  vga_frame_mem_arbiter #(
    .AW(16), .DW(8), .BLANK_ONLY(1), .STARVE_LIMIT(4095)
  ) dut_b (
    .CLK(clk), .RSTN(rstn), .IN_BLANK(in_blank),
    .DISP_REQ(disp_req), .DISP_ADDR(disp_addr),
    .DISP_DATA(disp_data_b), .DISP_VALID(disp_valid_b),
    .HOST_REQ(host_req), .HOST_WE(host_we), .HOST_ADDR(host_addr),
    .HOST_WDATA(host_wdata), .HOST_GNT(host_gnt_b),
    .HOST_RDATA(host_rdata_b), .HOST_RVALID(host_rvalid_b),
    .HOST_STARVE(host_starve_b),
    .MEM_ADDR(mem_addr_b), .MEM_WE(mem_we_b), .MEM_WDATA(mem_wdata_b),
    .MEM_RDATA(mem_rdata_b)
  );

  assign mem_rdata_b = 8'h00;

  // Synchronous single-port RAM model for dut_a, 256 words, preloaded
  // while ram_init is high.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[8'h10] <= 8'hA5;
      ram[8'h20] <= 8'h11;
      ram[8'h21] <= 8'h22;
      ram[8'h22] <= 8'h33;
      mem_rdata_a <= 8'h00;
    end else begin
      if (mem_we_a) ram[mem_addr_a[7:0]] <= mem_wdata_a;
      mem_rdata_a <= ram[mem_addr_a[7:0]];
    end
  end

  // Drives one cycle of inputs and waits until outputs have settled.
  task automatic applyStimulus(input logic dreq, input logic [15:0] daddr,
                               input logic hreq, input logic hwe,
                               input logic [15:0] haddr, input logic [7:0] hwdata,
                               input logic blank);
    @(negedge clk);
    disp_req   = dreq;
    disp_addr  = daddr;
    host_req   = hreq;
    host_we    = hwe;
    host_addr  = haddr;
    host_wdata = hwdata;
    in_blank   = blank;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn       = 1'b0;
    ram_init   = 1'b1;
    in_blank   = 1'b0;
    disp_req   = 1'b0;
    disp_addr  = 16'h0000;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 16'h0000;
    host_wdata = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_disp_valid", 32'(disp_valid_a), 32'd0);
    checkOutput("rst_host_gnt", 32'(host_gnt_a), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we_a), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    checkOutput("rst_starve", 32'(host_starve_a), 32'd0);
    @(negedge clk);
    ram_init = 1'b0;
    rstn     = 1'b1;

    // Display read of 0x0010 returns 0xA5 two cycles later
    $display("[TB] display read latency");
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t1_mem_addr", 32'(mem_addr_a), 32'h0010);
    checkOutput("t1_mem_we", 32'(mem_we_a), 32'd0);
    checkOutput("t1_host_gnt", 32'(host_gnt_a), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t1_valid_n1", 32'(disp_valid_a), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t1_valid_n2", 32'(disp_valid_a), 32'd1);
    checkOutput("t1_data_n2", 32'(disp_data_a), 32'h00A5);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t1_valid_n3", 32'(disp_valid_a), 32'd0);
    checkOutput("t1_data_hold", 32'(disp_data_a), 32'h00A5);

    // Host write with no display request: same-cycle grant, no read return
    $display("[TB] host write");
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 8'h3C, 1'b0);
    checkOutput("t2_host_gnt", 32'(host_gnt_a), 32'd1);
    checkOutput("t2_mem_we", 32'(mem_we_a), 32'd1);
    checkOutput("t2_mem_addr", 32'(mem_addr_a), 32'h1234);
    checkOutput("t2_mem_wdata", 32'(mem_wdata_a), 32'h003C);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t2_addr_park", 32'(mem_addr_a), 32'h1234);
    checkOutput("t2_we_idle", 32'(mem_we_a), 32'd0);
    checkOutput("t2_gnt_idle", 32'(host_gnt_a), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t2_no_rvalid", 32'(host_rvalid_a), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t2_no_rvalid2", 32'(host_rvalid_a), 32'd0);

    // Contention: display wins three cycles, host read of 0x0034 (now 0x3C)
    $display("[TB] display/host contention");
    applyStimulus(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0034, 8'h00, 1'b0);
    checkOutput("t3_gnt_c0", 32'(host_gnt_a), 32'd0);
    checkOutput("t3_addr_c0", 32'(mem_addr_a), 32'h0020);
    applyStimulus(1'b1, 16'h0021, 1'b1, 1'b0, 16'h0034, 8'h00, 1'b0);
    checkOutput("t3_gnt_c1", 32'(host_gnt_a), 32'd0);
    applyStimulus(1'b1, 16'h0022, 1'b1, 1'b0, 16'h0034, 8'h00, 1'b0);
    checkOutput("t3_gnt_c2", 32'(host_gnt_a), 32'd0);
    checkOutput("t3_dvalid_c2", 32'(disp_valid_a), 32'd1);
    checkOutput("t3_ddata_c2", 32'(disp_data_a), 32'h0011);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0034, 8'h00, 1'b0);
    checkOutput("t3_gnt_c3", 32'(host_gnt_a), 32'd1);
    checkOutput("t3_addr_c3", 32'(mem_addr_a), 32'h0034);
    checkOutput("t3_dvalid_c3", 32'(disp_valid_a), 32'd1);
    checkOutput("t3_ddata_c3", 32'(disp_data_a), 32'h0022);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t3_dvalid_c4", 32'(disp_valid_a), 32'd1);
    checkOutput("t3_ddata_c4", 32'(disp_data_a), 32'h0033);
    checkOutput("t3_hvalid_c4", 32'(host_rvalid_a), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t3_dvalid_c5", 32'(disp_valid_a), 32'd0);
    checkOutput("t3_hvalid_c5", 32'(host_rvalid_a), 32'd1);
    checkOutput("t3_hdata_c5", 32'(host_rdata_a), 32'h003C);
    checkOutput("t3_ddata_hold", 32'(disp_data_a), 32'h0033);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t3_hvalid_c6", 32'(host_rvalid_a), 32'd0);
    checkOutput("t3_hdata_hold", 32'(host_rdata_a), 32'h003C);

    // Blank-only instance: no grant in the active window, grant on blank
    $display("[TB] blank-only host access");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b0);
      checkOutput("t4_b_no_gnt", 32'(host_gnt_b), 32'd0);
      checkOutput("t4_a_gnt", 32'(host_gnt_a), 32'd1);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b1);
    checkOutput("t4_b_gnt_blank", 32'(host_gnt_b), 32'd1);
    checkOutput("t4_b_addr", 32'(mem_addr_b), 32'h0005);
    applyStimulus(1'b1, 16'h0021, 1'b1, 1'b0, 16'h0005, 8'h00, 1'b1);
    checkOutput("t4_b_disp_wins", 32'(host_gnt_b), 32'd0);
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

    // Starvation: continuous display traffic, host read held
    $display("[TB] host starvation");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'h0021, 1'b1, 1'b0, 16'h0034, 8'h00, 1'b0);
      checkOutput("t5_starve_low", 32'(host_starve_a), 32'd0);
      checkOutput("t5_gnt_low", 32'(host_gnt_a), 32'd0);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0034, 8'h00, 1'b0);
    checkOutput("t5_gnt", 32'(host_gnt_a), 32'd1);
    checkOutput("t5_starve_set", 32'(host_starve_a), 32'd1);
    repeat (2) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t5_starve_sticky", 32'(host_starve_a), 32'd1);
    checkOutput("t5_hdata", 32'(host_rdata_a), 32'h003C);
    checkOutput("t5_ddata", 32'(disp_data_a), 32'h0022);

    // Reset right after a display read issue cancels the read
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0077, 8'hEE, 1'b1);
    rstn = 1'b0;
    #1;
    checkOutput("t6_disp_valid", 32'(disp_valid_a), 32'd0);
    checkOutput("t6_disp_data", 32'(disp_data_a), 32'd0);
    checkOutput("t6_host_rdata", 32'(host_rdata_a), 32'd0);
    checkOutput("t6_host_rvalid", 32'(host_rvalid_a), 32'd0);
    checkOutput("t6_starve", 32'(host_starve_a), 32'd0);
    checkOutput("t6_host_gnt", 32'(host_gnt_a), 32'd0);
    checkOutput("t6_host_gnt_b", 32'(host_gnt_b), 32'd0);
    checkOutput("t6_mem_addr", 32'(mem_addr_a), 32'd0);
    checkOutput("t6_mem_we", 32'(mem_we_a), 32'd0);
    checkOutput("t6_mem_wdata", 32'(mem_wdata_a), 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
    checkOutput("t6_valid_in_rst", 32'(disp_valid_a), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
      checkOutput("t6_no_valid", 32'(disp_valid_a), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
